// File: rtl/qam_symbol_packer.sv
// Readout stage: pops demapped symbols from the symbol FIFO, packs them MSB-first
// into bytes and hands them to the host over valid/ready, zero-padding a trailing partial byte.
module qam_symbol_packer #(
    parameter int BITS_PER_SYM = 4,
    parameter int CNT_W        = 16
) (
    input  logic             dclk,
    input  logic             reset,
    input  logic             available,
    input  logic             rdempty,
    input  logic [BITS_PER_SYM-1:0] fifo_q,
    input  logic             abort,
    input  logic             out_ready,
    output logic             read_enable,
    output logic             rdreq,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] byte_count
);
    localparam int SPB = 8 / BITS_PER_SYM;
    localparam int SCW = (SPB > 1) ? $clog2(SPB) : 1;

    typedef enum logic [2:0] {IDLE, ARM, FETCH, LOAD, EMIT, DONE} state_t;

    state_t           state, state_n;
    logic [7:0]       sh, sh_n, sh_load, out_data_n;
    logic [SCW-1:0]   sym_cnt, sym_cnt_n;
    logic             flush, flush_n;
    logic             read_enable_n, rdreq_n, out_valid_n, done_n;
    logic [CNT_W-1:0] byte_count_n;
    logic [3:0]       pad;

    // Shifting by BITS_PER_SYM also covers the 8-bit mode, where the old contents fall out.
    assign sh_load = (sh << BITS_PER_SYM) | 8'(fifo_q);
    assign pad     = 4'(BITS_PER_SYM * (SPB - int'(sym_cnt)));

    always_comb begin
        state_n       = state;
        sh_n          = sh;
        sym_cnt_n     = sym_cnt;
        flush_n       = flush;
        out_data_n    = out_data;
        out_valid_n   = out_valid;
        byte_count_n  = byte_count;
        read_enable_n = 1'b0;
        rdreq_n       = 1'b0;

        if (abort && state != IDLE) begin
            state_n     = IDLE;
            out_valid_n = 1'b0;
            sh_n        = '0;
            sym_cnt_n   = '0;
            flush_n     = 1'b0;
        end else begin
            // rdreq is registered, so the pop is issued on entry to FETCH from the empty flag
            // seen in the preceding cycle; FETCH then only needs to check that it was issued.
            unique case (state)
                IDLE: if (available) begin
                    state_n       = ARM;
                    byte_count_n  = '0;
                    read_enable_n = 1'b1;
                end
                ARM: begin
                    state_n = FETCH;
                    rdreq_n = !rdempty;
                end
                FETCH: begin
                    if (rdreq) begin
                        state_n = LOAD;
                    end else if (!rdempty) begin
                        rdreq_n = 1'b1;
                    end else if (sym_cnt == '0) begin
                        state_n = DONE;
                    end else begin
                        out_data_n  = sh << pad;
                        out_valid_n = 1'b1;
                        flush_n     = 1'b1;
                        state_n     = EMIT;
                    end
                end
                LOAD: begin
                    sh_n = sh_load;
                    if (sym_cnt == SCW'(SPB - 1)) begin
                        out_data_n  = sh_load;
                        out_valid_n = 1'b1;
                        sym_cnt_n   = '0;
                        state_n     = EMIT;
                    end else begin
                        sym_cnt_n = sym_cnt + 1'b1;
                        state_n   = FETCH;
                        rdreq_n   = !rdempty;
                    end
                end
                EMIT: if (out_ready) begin
                    out_valid_n = 1'b0;
                    if (byte_count != '1)
                        byte_count_n = byte_count + 1'b1;
                    if (flush) begin
                        state_n = DONE;
                    end else begin
                        state_n = FETCH;
                        rdreq_n = !rdempty;
                    end
                end
                DONE: begin
                    sh_n      = '0;
                    sym_cnt_n = '0;
                    flush_n   = 1'b0;
                    state_n   = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
        done_n = (state_n == DONE);
    end

    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sh          <= '0;
            sym_cnt     <= '0;
            flush       <= 1'b0;
            read_enable <= 1'b0;
            rdreq       <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            byte_count  <= '0;
        end else begin
            state       <= state_n;
            sh          <= sh_n;
            sym_cnt     <= sym_cnt_n;
            flush       <= flush_n;
            read_enable <= read_enable_n;
            rdreq       <= rdreq_n;
            out_data    <= out_data_n;
            out_valid   <= out_valid_n;
            done        <= done_n;
            busy        <= (state_n != IDLE);
            byte_count  <= byte_count_n;
        end
    end
endmodule

// File: tb/tb_qam_symbol_packer.sv
// Directed bench for qam_symbol_packer: a 4-bit and a 2-bit instance, each fed by a small FIFO model.
module tb_qam_symbol_packer;
    logic dclk  = 1'b0;
    logic reset = 1'b1;
    always #5 dclk = ~dclk;

    logic        available4 = 1'b0, abort4 = 1'b0, out_ready4 = 1'b0;
    logic        rdempty4, read_enable4, rdreq4, out_valid4, done4, busy4;
    logic [3:0]  fifo_q4;
    logic [7:0]  out_data4;
    logic [15:0] byte_count4;

    logic        available2 = 1'b0, abort2 = 1'b0, out_ready2 = 1'b0;
    logic        rdempty2, read_enable2, rdreq2, out_valid2, done2, busy2;
    logic [1:0]  fifo_q2;
    logic [7:0]  out_data2;
    logic [15:0] byte_count2;

    qam_symbol_packer #(.BITS_PER_SYM(4), .CNT_W(16)) u_dut4 (
        .dclk(dclk), .reset(reset), .available(available4), .rdempty(rdempty4),
        .fifo_q(fifo_q4), .abort(abort4), .out_ready(out_ready4),
        .read_enable(read_enable4), .rdreq(rdreq4), .out_data(out_data4),
        .out_valid(out_valid4), .done(done4), .busy(busy4), .byte_count(byte_count4)
    );

    qam_symbol_packer #(.BITS_PER_SYM(2), .CNT_W(16)) u_dut2 (
        .dclk(dclk), .reset(reset), .available(available2), .rdempty(rdempty2),
        .fifo_q(fifo_q2), .abort(abort2), .out_ready(out_ready2),
        .read_enable(read_enable2), .rdreq(rdreq2), .out_data(out_data2),
        .out_valid(out_valid2), .done(done2), .busy(busy2), .byte_count(byte_count2)
    );

    // FIFO models: data appears the cycle after rdreq, empty flag follows the pop.
    logic [3:0] q4[$];
    logic [1:0] q2[$];
    always @(posedge dclk) begin
        if (rdreq4 && q4.size() != 0) fifo_q4 <= q4.pop_front();
        rdempty4 <= (q4.size() == 0);
    end
    always @(posedge dclk) begin
        if (rdreq2 && q2.size() != 0) fifo_q2 <= q2.pop_front();
        rdempty2 <= (q2.size() == 0);
    end

    int cyc = 0;
    always @(posedge dclk) cyc <= cyc + 1;

    int rdreq_n4 = 0, done_n4 = 0, ov_n4 = 0, xfer_n4 = 0, empty_pop4 = 0;
    int re_cyc4 = 0, rdreq_cyc4 = 0, rise_cyc4 = 0, done_cyc4 = 0, xfer_cyc4 = 0;
    logic       ov_prev4 = 1'b0;
    logic [7:0] bytes4 [0:63];
    always @(negedge dclk) if (!reset) begin
        if (read_enable4) re_cyc4 <= cyc;
        if (rdreq4) begin
            rdreq_n4 <= rdreq_n4 + 1;
            if (rdreq_cyc4 < re_cyc4) rdreq_cyc4 <= cyc;
            if (rdempty4) empty_pop4 <= empty_pop4 + 1;
        end
        if (done4) begin
            done_n4   <= done_n4 + 1;
            done_cyc4 <= cyc;
        end
        if (out_valid4) ov_n4 <= ov_n4 + 1;
        if (out_valid4 && !ov_prev4 && rise_cyc4 < re_cyc4) rise_cyc4 <= cyc;
        if (out_valid4 && out_ready4) begin
            bytes4[xfer_n4 % 64] <= out_data4;
            xfer_n4   <= xfer_n4 + 1;
            xfer_cyc4 <= cyc;
        end
        ov_prev4 <= out_valid4;
    end

    int xfer_n2 = 0, done_n2 = 0;
    logic [7:0] last2 = 8'h00;
    always @(negedge dclk) if (!reset) begin
        if (out_valid2 && out_ready2) begin
            last2   <= out_data2;
            xfer_n2 <= xfer_n2 + 1;
        end
        if (done2) done_n2 <= done_n2 + 1;
    end

    int n_cmp = 0, n_bad = 0;
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_avail4();
        @(negedge dclk) available4 = 1'b1;
        @(negedge dclk) available4 = 1'b0;
    endtask

    task automatic wait_done4(input string tag, input int base);
        int k = 0;
        while (done_n4 == base && k < 200) begin
            @(negedge dclk);
            k++;
        end
        if (done_n4 == base) check_val({tag, "_timeout"}, 32'd0, 32'd1);
        repeat (2) @(negedge dclk);
    endtask

    task automatic wait_valid4(input string tag);
        int k = 0;
        while (!out_valid4 && k < 100) begin
            @(negedge dclk);
            k++;
        end
        if (!out_valid4) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    int b_rd, b_done, b_x, b_ov, k, stall_bad;

    initial begin
        repeat (3) @(negedge dclk);
        check_val("reset_outs4", 32'({read_enable4, rdreq4, out_valid4, done4, busy4, out_data4, byte_count4}), 32'd0);
        check_val("reset_outs2", 32'({read_enable2, rdreq2, out_valid2, done2, busy2, out_data2, byte_count2}), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge dclk);

        // Packing order: A,5,3,C -> A5, 3C
        out_ready4 = 1'b1;
        q4.push_back(4'hA); q4.push_back(4'h5); q4.push_back(4'h3); q4.push_back(4'hC);
        @(negedge dclk);
        b_rd = rdreq_n4; b_done = done_n4; b_x = xfer_n4;
        pulse_avail4();
        wait_done4("pack", b_done);
        check_val("pack_byte0", 32'(bytes4[b_x % 64]), 32'hA5);
        check_val("pack_byte1", 32'(bytes4[(b_x + 1) % 64]), 32'h3C);
        check_val("pack_nbytes", xfer_n4 - b_x, 2);
        check_val("pack_byte_count", 32'(byte_count4), 32'd2);
        check_val("pack_done_pulses", done_n4 - b_done, 1);
        check_val("pack_rdreq_pulses", rdreq_n4 - b_rd, 4);
        check_val("pack_rdreq_lat", rdreq_cyc4 - re_cyc4, 1);
        check_val("pack_valid_lat", rise_cyc4 - re_cyc4, 5);

        // Partial flush: A,5,7 -> A5, 70
        q4.push_back(4'hA); q4.push_back(4'h5); q4.push_back(4'h7);
        @(negedge dclk);
        b_done = done_n4; b_x = xfer_n4;
        pulse_avail4();
        wait_done4("flush", b_done);
        check_val("flush_byte0", 32'(bytes4[b_x % 64]), 32'hA5);
        check_val("flush_byte1", 32'(bytes4[(b_x + 1) % 64]), 32'h70);
        check_val("flush_done_after_xfer", done_cyc4 - xfer_cyc4, 1);
        check_val("flush_byte_count", 32'(byte_count4), 32'd2);

        // Backpressure: 10 stalled cycles on A5
        out_ready4 = 1'b0;
        q4.push_back(4'hA); q4.push_back(4'h5);
        @(negedge dclk);
        b_done = done_n4; b_x = xfer_n4;
        pulse_avail4();
        wait_valid4("bp_valid");
        check_val("bp_count_before", 32'(byte_count4), 32'd0);
        b_rd = rdreq_n4;
        stall_bad = 0;
        repeat (10) begin
            if (out_valid4 !== 1'b1 || out_data4 !== 8'hA5) stall_bad++;
            @(negedge dclk);
        end
        check_val("bp_stable", stall_bad, 0);
        check_val("bp_no_rdreq", rdreq_n4 - b_rd, 0);
        out_ready4 = 1'b1;
        @(posedge dclk);
        #1;
        check_val("bp_valid_dropped", 32'(out_valid4), 32'd0);
        check_val("bp_count_after", 32'(byte_count4), 32'd1);
        wait_done4("bp", b_done);
        check_val("bp_byte", 32'(bytes4[b_x % 64]), 32'hA5);
        check_val("bp_nbytes", xfer_n4 - b_x, 1);

        // Empty FIFO
        b_rd = rdreq_n4; b_done = done_n4; b_x = xfer_n4; b_ov = ov_n4;
        pulse_avail4();
        wait_done4("empty", b_done);
        check_val("empty_done_lat", done_cyc4 - re_cyc4, 2);
        check_val("empty_no_rdreq", rdreq_n4 - b_rd, 0);
        check_val("empty_no_valid", ov_n4 - b_ov, 0);
        check_val("empty_byte_count", 32'(byte_count4), 32'd0);

        // Abort during EMIT of the second byte
        q4.push_back(4'hA); q4.push_back(4'h5); q4.push_back(4'h3); q4.push_back(4'hC);
        @(negedge dclk);
        b_done = done_n4; b_x = xfer_n4;
        pulse_avail4();
        k = 0;
        while (xfer_n4 == b_x && k < 100) begin
            @(negedge dclk);
            k++;
        end
        out_ready4 = 1'b0;
        wait_valid4("abort_valid");
        check_val("abort_data_pre", 32'(out_data4), 32'h3C);
        abort4 = 1'b1;
        @(posedge dclk);
        #1;
        check_val("abort_valid_low", 32'(out_valid4), 32'd0);
        check_val("abort_idle", 32'(busy4), 32'd0);
        check_val("abort_count_kept", 32'(byte_count4), 32'd1);
        @(negedge dclk) abort4 = 1'b0;
        repeat (4) @(negedge dclk);
        check_val("abort_no_done", done_n4 - b_done, 0);

        // 2-bit mode: 3,0,2,1 -> C9
        out_ready2 = 1'b1;
        q2.push_back(2'd3); q2.push_back(2'd0); q2.push_back(2'd2); q2.push_back(2'd1);
        @(negedge dclk) available2 = 1'b1;
        @(negedge dclk) available2 = 1'b0;
        k = 0;
        while (done_n2 == 0 && k < 200) begin
            @(negedge dclk);
            k++;
        end
        if (done_n2 == 0) check_val("mode2_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge dclk);
        check_val("mode2_byte", 32'(last2), 32'hC9);
        check_val("mode2_nbytes", xfer_n2, 1);
        check_val("mode2_byte_count", 32'(byte_count2), 32'd1);

        // Reset during LOAD clears outputs without a clock edge
        out_ready4 = 1'b1;
        q4.push_back(4'hA); q4.push_back(4'h5); q4.push_back(4'h3); q4.push_back(4'hC);
        @(negedge dclk);
        pulse_avail4();
        k = 0;
        while (!rdreq4 && k < 50) begin
            @(negedge dclk);
            k++;
        end
        if (!rdreq4) check_val("rst_rdreq_timeout", 32'd0, 32'd1);
        @(posedge dclk);
        #2;
        check_val("rst_busy_pre", 32'(busy4), 32'd1);
        reset = 1'b1;
        #1;
        check_val("rst_async_outs", 32'({read_enable4, rdreq4, out_valid4, done4, busy4, out_data4, byte_count4}), 32'd0);
        @(negedge dclk);
        q4.delete();
        @(negedge dclk) reset = 1'b0;
        repeat (2) @(negedge dclk);

        check_val("no_rdreq_when_empty", empty_pop4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
